// File: rtl/regfile_dump_sequencer.sv
// Purpose : walks a register index range on the register file debug read port
//           (Debug_Source_select / Debug_out) and streams {index, data} beats.
// Latency : first beat valid 2 cycles after start is raised; at most 1 beat per 2 cycles.
// Backpr. : a beat is held stable in HOLD until out_valid & out_ready; nothing is dropped except on abort.
//
// Ports
//   clk, reset            : system clock, synchronous active-high reset
//   start, abort          : begin a dump (IDLE only) / cancel immediately (beats dropped)
//   first_idx, last_idx   : inclusive index range, sampled on an accepted start
//   dbg_sel, dbg_data     : register file debug select / combinational read data
//   out_valid/ready/index/data : {index, data} beat stream toward the debug formatter
//   busy, done            : dump in progress / one-cycle pulse on normal completion
module regfile_dump_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [4:0]       first_idx,
    input  logic [4:0]       last_idx,
    output logic [4:0]       dbg_sel,
    input  logic [WIDTH-1:0] dbg_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       out_index,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SELECT = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    state_t           r_state;
    logic [4:0]       r_dbg_sel;
    logic [4:0]       r_last;
    logic             r_out_valid;
    logic [4:0]       r_out_index;
    logic [WIDTH-1:0] r_out_data;
    logic             r_done;

    state_t           w_state;
    logic [4:0]       w_dbg_sel;
    logic [4:0]       w_last;
    logic             w_out_valid;
    logic [4:0]       w_out_index;
    logic [WIDTH-1:0] w_out_data;
    logic             w_done;
    logic             w_handshake;

    assign w_handshake = r_out_valid & out_ready;

    always_comb begin
        w_state     = r_state;
        w_dbg_sel   = r_dbg_sel;
        w_last      = r_last;
        w_out_valid = r_out_valid;
        w_out_index = r_out_index;
        w_out_data  = r_out_data;
        w_done      = 1'b0;

        if (abort) begin
            // Cancel from any state: drop a pending beat, no done pulse.
            w_state     = S_IDLE;
            w_out_valid = 1'b0;
            w_dbg_sel   = 5'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_last = last_idx;
                        if (first_idx <= last_idx) begin
                            w_dbg_sel = first_idx;
                            w_state   = S_SELECT;
                        end else begin
                            // Empty range: complete immediately without beats.
                            w_done = 1'b1;
                        end
                    end
                end
                S_SELECT: begin
                    // dbg_sel has been stable all cycle and the read is
                    // combinational, so dbg_data is settled here. Capturing it
                    // makes the beat immune to later writes of that register.
                    w_out_data  = dbg_data;
                    w_out_index = r_dbg_sel;
                    w_out_valid = 1'b1;
                    w_state     = S_HOLD;
                end
                S_HOLD: begin
                    if (w_handshake) begin
                        w_out_valid = 1'b0;
                        if (r_out_index == r_last) begin
                            // Stop on equality so 31 never wraps to 0.
                            w_done  = 1'b1;
                            w_state = S_IDLE;
                        end else begin
                            w_dbg_sel = r_dbg_sel + 5'd1;
                            w_state   = S_SELECT;
                        end
                    end
                end
                default: begin
                    w_state     = S_IDLE;
                    w_out_valid = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_dbg_sel   <= 5'd0;
            r_last      <= 5'd0;
            r_out_valid <= 1'b0;
            r_out_index <= 5'd0;
            r_out_data  <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_dbg_sel   <= w_dbg_sel;
            r_last      <= w_last;
            r_out_valid <= w_out_valid;
            r_out_index <= w_out_index;
            r_out_data  <= w_out_data;
            r_done      <= w_done;
        end
    end

    assign dbg_sel   = r_dbg_sel;
    assign out_valid = r_out_valid;
    assign out_index = r_out_index;
    assign out_data  = r_out_data;
    assign done      = r_done;
    assign busy      = (r_state == S_SELECT) || (r_state == S_HOLD);

endmodule

// File: tb/tb_regfile_dump_sequencer.sv
// Purpose : directed + randomized checks of regfile_dump_sequencer against a
//           queue-based reference (expected beats = registers first..last in order).
module tb_regfile_dump_sequencer;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start, abort, out_ready;
    logic [4:0]   first_idx, last_idx, dbg_sel, out_index;
    logic [W-1:0] dbg_data, out_data;
    logic         out_valid, busy, done;

    logic [W-1:0] regs [32];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Register file model: x0 hardwired to zero, combinational debug read.
    assign dbg_data = (dbg_sel == 5'd0) ? '0 : regs[dbg_sel];

    regfile_dump_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .first_idx(first_idx), .last_idx(last_idx), .dbg_sel(dbg_sel),
        .dbg_data(dbg_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_index(out_index), .out_data(out_data), .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode 0: ready always high; 1: random ready; 2: ready low for 4 cycles on
    // the first beat, then high. wr_hold rewrites the first beat's register
    // while it is stalled. busy_start pulses a conflicting start mid-dump.
    task automatic run_dump(input int f, input int l, input int mode,
                            input bit wr_hold, input bit busy_start);
        logic [4:0]   q_idx[$];
        logic [W-1:0] q_dat[$];
        int n, cyc, got, stall_left;
        bit fin, seen, pv, phs;
        logic [4:0]   pidx;
        logic [W-1:0] pdat;
        n = (l >= f) ? (l - f + 1) : 0;
        for (int i = f; i <= l; i++) begin
            q_idx.push_back(5'(i));
            q_dat.push_back((i == 0) ? '0 : regs[i]);
        end
        start = 1'b1; first_idx = 5'(f); last_idx = 5'(l); out_ready = 1'b0;
        step();
        start = 1'b0;
        cyc = 1; got = 0; stall_left = 4; fin = 0; seen = 0; pv = 0; phs = 0;
        pidx = '0; pdat = '0;
        while (!fin && cyc < 2000) begin
            if (busy_start && cyc == 3) begin
                start = 1'b1; first_idx = 5'd0; last_idx = 5'd1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                check("busy_low_at_done", 64'(busy), 64'(0));
                check("beat_count", 64'(got), 64'(n));
                check("valid_low_at_done", 64'(out_valid), 64'(0));
                if (mode == 0) check("done_latency", 64'(cyc), 64'(2 * n + 1));
                fin = 1;
            end else begin
                check("busy_during_dump", 64'(busy), 64'(1));
                if (pv && !phs)
                    check("stall_stable", 64'({out_valid, out_index, out_data}),
                          64'({1'b1, pidx, pdat}));
                if (out_valid) begin
                    if (mode == 0 && !seen) check("first_beat_latency", 64'(cyc), 64'(2));
                    if (wr_hold && !seen) begin
                        @(negedge clk);
                        regs[out_index] = 32'h5A5A5A5A;
                    end
                    seen = 1;
                    case (mode)
                        0: out_ready = 1'b1;
                        1: out_ready = 1'($urandom_range(0, 1));
                        default: begin
                            if (stall_left > 0) begin
                                stall_left--;
                                out_ready = 1'b0;
                            end else begin
                                out_ready = 1'b1;
                            end
                        end
                    endcase
                    if (out_ready) begin
                        if (q_idx.size() == 0) begin
                            check("unexpected_beat", 64'(out_index), 64'(32));
                        end else begin
                            check("beat", 64'({out_index, out_data}),
                                  64'({q_idx[0], q_dat[0]}));
                            void'(q_idx.pop_front());
                            void'(q_dat.pop_front());
                        end
                        got++;
                    end
                end else begin
                    out_ready = 1'($urandom_range(0, 1));
                end
                pv = out_valid; phs = out_valid && out_ready;
                pidx = out_index; pdat = out_data;
            end
            if (!fin) begin
                step();
                cyc++;
            end
        end
        start = 1'b0;
        if (!fin) check("dump_timeout", 64'(0), 64'(1));
        step();
        check("idle_after_done", 64'({done, out_valid, busy}), 64'(0));
    endtask

    initial begin
        int t;
        reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        first_idx = '0; last_idx = '0;
        for (int i = 0; i < 32; i++) regs[i] = $urandom();
        regs[1] = 32'h11111111;
        regs[5] = 32'hDEADBEEF;
        step(); step();
        check("reset_state", 64'({dbg_sel, out_valid, out_index, out_data, busy, done}), 64'(0));
        reset = 1'b0;
        step();

        // Basic dump 0..5 with ready tied high.
        run_dump(0, 5, 0, 0, 0);
        // Backpressure on range 3..4.
        run_dump(3, 4, 2, 0, 0);
        // Empty range and top single register.
        run_dump(7, 2, 0, 0, 0);
        run_dump(31, 31, 0, 0, 0);
        // Write during HOLD: captured value must persist.
        regs[9] = 32'hA5A5A5A5;
        run_dump(9, 9, 2, 1, 0);
        check("x9_rewritten", 64'(regs[9]), 64'(32'h5A5A5A5A));

        // Abort in HOLD at index 10 of 0..31.
        start = 1'b1; first_idx = 5'd0; last_idx = 5'd31; out_ready = 1'b1;
        step();
        start = 1'b0;
        t = 0;
        while (!(out_valid && out_index == 5'd10) && t < 200) begin
            step();
            t++;
        end
        check("reach_index10", 64'({out_valid, out_index}), 64'({1'b1, 5'd10}));
        abort = 1'b1; out_ready = 1'b0;
        step();
        abort = 1'b0;
        check("after_abort", 64'({out_valid, busy, dbg_sel, done}), 64'(0));
        step();
        check("no_done_after_abort", 64'({done, busy, out_valid}), 64'(0));
        run_dump(0, 31, 1, 0, 0);

        // Abort and start together in IDLE: nothing starts.
        start = 1'b1; abort = 1'b1; first_idx = 5'd0; last_idx = 5'd3;
        step();
        start = 1'b0; abort = 1'b0;
        step();
        check("abort_beats_start", 64'({busy, out_valid, done}), 64'(0));

        // Start while busy must not disturb the running dump.
        run_dump(2, 20, 1, 0, 1);

        // Reset mid-dump.
        start = 1'b1; first_idx = 5'd0; last_idx = 5'd31; out_ready = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 7; i++) step();
        reset = 1'b1;
        step();
        check("mid_reset", 64'({dbg_sel, out_valid, out_index, out_data, busy, done}), 64'(0));
        reset = 1'b0;
        step();
        check("no_done_after_reset", 64'({done, busy}), 64'(0));

        // Randomized ranges with random backpressure.
        for (int k = 0; k < 12; k++) begin
            int a, b;
            a = $urandom_range(0, 31);
            b = $urandom_range(0, 31);
            for (int i = 1; i < 32; i++) regs[i] = $urandom();
            run_dump(a, b, (k % 2 == 0) ? 0 : 1, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
